// File: rtl/sfp_sum_link.sv
// Receive-side partial-sum link: pops one remote row sum per request
// and holds it on sum_in until the local divide step consumes it.
module sfp_sum_link #(
  parameter int bw      = 8,
  parameter int bw_psum = 2*bw+4,
  parameter int sum_bw  = bw_psum+4,
  parameter int depth   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              remote_wr,
  output logic              fifo_ext_rd,
  input  logic [sum_bw-1:0] sum_remote,
  input  logic              req,
  input  logic              consume,
  output logic [sum_bw-1:0] sum_in,
  output logic              sum_vld,
  output logic [4:0]        credit,
  output logic [15:0]       rows,
  output logic              err_ovf,
  output logic              err_req
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    POP,
    CAP
  } state_t;

  localparam logic [4:0] full = 5'(depth);

  state_t state;
  logic   pop;
  logic   at_full;

  assign pop     = (state == POP);
  assign at_full = (credit == full);

  // Pop strobe is gated by reset so a pop never leaks out of a reset cycle.
  assign fifo_ext_rd = pop & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      sum_in  <= '0;
      sum_vld <= 1'b0;
      credit  <= '0;
      rows    <= '0;
      err_ovf <= 1'b0;
      err_req <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            if (sum_vld)
              err_req <= 1'b1;
            else if (credit != '0)
              state <= POP;
            else
              state <= WAIT;
          end
        end
        WAIT: begin
          if (req)
            err_req <= 1'b1;
          // A write arriving now is credit by the time POP runs.
          if (credit != '0 || remote_wr)
            state <= POP;
        end
        POP: begin
          if (req)
            err_req <= 1'b1;
          state <= CAP;
        end
        CAP: begin
          if (req)
            err_req <= 1'b1;
          sum_in <= sum_remote;
          rows   <= rows + 16'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (state == CAP)
        sum_vld <= 1'b1;
      else if (consume)
        sum_vld <= 1'b0;

      if (remote_wr && at_full)
        err_ovf <= 1'b1;

      if (remote_wr && !pop && !at_full)
        credit <= credit + 5'd1;
      else if (!remote_wr && pop)
        credit <= credit - 5'd1;
    end
  end

endmodule

// File: tb/tb_sfp_sum_link.sv
// Bench for sfp_sum_link: remote FIFO model, directed timing checks,
// random request traffic with an in-order delivery scoreboard.
module tb_sfp_sum_link;

  localparam int SW = 24;
  localparam int DEPTH = 16;

  logic          clk = 0;
  logic          reset = 0;
  logic          remote_wr = 0;
  logic          fifo_ext_rd;
  logic [SW-1:0] sum_remote = '0;
  logic          req = 0;
  logic          consume = 0;
  logic [SW-1:0] sum_in;
  logic          sum_vld;
  logic [4:0]    credit;
  logic [15:0]   rows;
  logic          err_ovf;
  logic          err_req;

  logic [SW-1:0] wdata = '0;

  int checks = 0;
  int fails = 0;

  logic [SW-1:0] fifo_q[$];
  logic [SW-1:0] wlog[$];
  int            exp_q[$];
  int            pops = 0;
  int            delivered = 0;
  int            acc = 0;

  sfp_sum_link dut (
    .clk(clk),
    .reset(reset),
    .remote_wr(remote_wr),
    .fifo_ext_rd(fifo_ext_rd),
    .sum_remote(sum_remote),
    .req(req),
    .consume(consume),
    .sum_in(sum_in),
    .sum_vld(sum_vld),
    .credit(credit),
    .rows(rows),
    .err_ovf(err_ovf),
    .err_req(err_req)
  );

  always #5 clk = ~clk;

  // Remote FIFO with registered read, reset together with the DUT.
  always @(posedge clk) begin
    if (!reset) begin
      fifo_q.delete();
      wlog.delete();
      sum_remote <= '0;
      pops <= 0;
    end else begin
      if (fifo_ext_rd) begin
        pops <= pops + 1;
        if (fifo_q.size() > 0)
          sum_remote <= fifo_q.pop_front();
      end
      if (remote_wr) begin
        wlog.push_back(wdata);
        if (fifo_q.size() < DEPTH)
          fifo_q.push_back(wdata);
      end
    end
  end

  task automatic check(input string name,
                       input longint act,
                       input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Monitor: every fresh sum must be the next written remote sum.
  initial begin
    logic prev;
    int   idx;
    prev = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        delivered = 0;
        prev = 0;
      end else begin
        if (sum_vld && !prev) begin
          delivered++;
          check("rows_on_deliver", rows, delivered);
          if (exp_q.size() == 0) begin
            check("unexpected_delivery", 1, 0);
          end else begin
            idx = exp_q.pop_front();
            if (idx < wlog.size())
              check("sum_in_order", sum_in, wlog[idx]);
            else
              check("sum_idx_valid", idx, wlog.size());
          end
        end
        prev = sum_vld;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    remote_wr = 0;
    req = 0;
    consume = 0;
    exp_q.delete();
    acc = 0;
    tick();
    tick();
    reset = 1;
  endtask

  task automatic wr(input logic [SW-1:0] d);
    remote_wr = 1;
    wdata = d;
    tick();
    remote_wr = 0;
  endtask

  task automatic issue_req();
    req = 1;
    exp_q.push_back(acc);
    acc++;
    tick();
    req = 0;
  endtask

  task automatic wait_vld(input int budget);
    int n;
    n = 0;
    while (!sum_vld && n < budget) begin
      tick();
      n++;
    end
    if (!sum_vld)
      check("vld_timeout", 0, 1);
  endtask

  initial begin
    int mcred;
    int nw;
    logic [SW-1:0] hold;
    logic saw_rd;

    // Reset plus three writes
    do_reset();
    check("rst_sum_vld", sum_vld, 0);
    check("rst_sum_in", sum_in, 0);
    check("rst_credit", credit, 0);
    check("rst_rows", rows, 0);
    check("rst_errs", {err_ovf, err_req}, 0);
    wr(24'h111111);
    wr(24'h222222);
    wr(24'h333333);
    tick();
    check("credit_3", credit, 3);
    check("no_pops", pops, 0);
    check("idle_outs", {sum_vld, err_ovf, err_req, rows}, 0);

    // Basic latency with credit 2
    do_reset();
    wr(24'h001234);
    wr(24'habcdef);
    check("credit_2", credit, 2);
    issue_req();
    check("pop_t1", fifo_ext_rd, 1);
    check("vld_t1", sum_vld, 0);
    tick();
    check("nopop_t2", fifo_ext_rd, 0);
    check("vld_t2", sum_vld, 0);
    tick();
    check("vld_t3", sum_vld, 1);
    check("sum_t3", sum_in, 24'h001234);
    check("credit_after", credit, 1);
    check("rows_1", rows, 1);
    check("one_pop", pops, 1);
    consume = 1;
    tick();
    consume = 0;
    check("consume_vld", sum_vld, 0);
    check("consume_hold", sum_in, 24'h001234);

    // Request with no credit waits for the remote write
    do_reset();
    issue_req();
    saw_rd = 0;
    for (int i = 0; i < 5; i++) begin
      if (fifo_ext_rd || sum_vld) saw_rd = 1;
      tick();
    end
    check("wait_no_pop", saw_rd, 0);
    wr(24'h5a5a5a);
    check("wait_pop_u1", fifo_ext_rd, 1);
    tick();
    check("wait_vld_u2", sum_vld, 0);
    tick();
    check("wait_vld_u3", sum_vld, 1);
    check("wait_credit0", credit, 0);
    consume = 1;
    tick();
    consume = 0;

    // Write during POP leaves credit unchanged
    do_reset();
    wr(24'h0000aa);
    issue_req();
    check("pop_cycle", fifo_ext_rd, 1);
    wr(24'h0000bb);
    check("credit_same", credit, 1);
    tick();
    check("inc_dec_vld", sum_vld, 1);
    consume = 1;
    tick();
    consume = 0;

    // Saturation and sticky overflow
    do_reset();
    for (int i = 0; i < 17; i++)
      wr(SW'($urandom));
    check("sat_credit", credit, DEPTH);
    check("ovf_set", err_ovf, 1);
    tick();
    tick();
    check("ovf_sticky", err_ovf, 1);

    // Request while a sum is held
    do_reset();
    wr(24'h0c0ffe);
    wr(24'h0d0d0d);
    issue_req();
    wait_vld(6);
    hold = sum_in;
    check("errreq_clear", err_req, 0);
    req = 1;
    tick();
    req = 0;
    tick();
    tick();
    check("errreq_vld", err_req, 1);
    check("drop_no_pop", pops, 1);
    check("drop_hold", sum_in, hold);
    consume = 1;
    tick();
    consume = 0;

    // Request during POP
    do_reset();
    wr(24'h777777);
    issue_req();
    req = 1;
    tick();
    req = 0;
    check("errreq_pop", err_req, 1);
    tick();
    check("pop_req_vld", sum_vld, 1);
    check("pop_req_pops", pops, 1);
    check("pop_req_cred", credit, 0);
    consume = 1;
    tick();
    consume = 0;

    // Reset during POP
    do_reset();
    wr(24'h999999);
    wr(24'h888888);
    req = 1;
    tick();
    req = 0;
    reset = 0;
    #1;
    check("rst_pop_rd", fifo_ext_rd, 0);
    tick();
    check("rst_pop_cred", credit, 0);
    check("rst_pop_vld", sum_vld, 0);
    check("rst_pop_sum", sum_in, 0);
    exp_q.delete();
    acc = 0;
    reset = 1;
    wr(24'h121212);
    issue_req();
    check("rst_idle_pop", fifo_ext_rd, 1);
    tick();
    tick();
    consume = 1;
    tick();
    consume = 0;

    // Random traffic
    do_reset();
    mcred = 0;
    for (int it = 0; it < 40; it++) begin
      nw = $urandom_range(0, 3);
      if (mcred == 0 && nw == 0) nw = 1;
      for (int k = 0; k < nw; k++) begin
        if (mcred < DEPTH) begin
          wr(SW'($urandom));
          mcred++;
        end
      end
      for (int k = $urandom_range(0, 2); k > 0; k--)
        tick();
      issue_req();
      mcred--;
      wait_vld(8);
      check("rand_credit", credit, mcred);
      consume = 1;
      tick();
      consume = 0;
      tick();
    end
    check("rand_pops", pops, acc);
    check("rand_no_err", {err_ovf, err_req}, 0);
    check("rand_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
